// File: rtl/cpu7_ifu_fcl_pkg.sv
// Shared definitions for the IFU fetch control logic: pc_bf select indices,
// FSM encoding and drop-counter sizing.
package cpu7_ifu_fcl_pkg;

  localparam int FCL_DROP_MAX = 3;
  localparam int FCL_DROP_W   = 2;
  localparam int PCBF_SEL_W   = 6;

  typedef enum logic [2:0] {
    SEL_INIT  = 3'd0,
    SEL_OLD   = 3'd1,
    SEL_PCINC = 3'd2,
    SEL_BRPC  = 3'd3,
    SEL_EXCPC = 3'd4,
    SEL_ERTN  = 3'd5
  } pcbf_idx_e;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } fcl_state_e;

  typedef logic [PCBF_SEL_W-1:0] pcbf_sel_t;

  function automatic pcbf_sel_t pcbf_onehot(input pcbf_idx_e idx);
    pcbf_sel_t one;
    one = 6'd1;
    return one << idx;
  endfunction

endpackage

// File: rtl/cpu7_ifu_fcl_if.sv
// Fetch-control handshake bundle: EXU redirect/stall, instruction-memory port
// and the fdp-facing select/valid outputs.
interface cpu7_ifu_fcl_if;
  import cpu7_ifu_fcl_pkg::*;

  logic      br_taken;
  logic      exu_ifu_except;
  logic      exu_ifu_ertn_e;
  logic      exu_ifu_stall_req;
  logic      inst_addr_ok;
  logic      inst_valid_f;
  logic      inst_req;
  logic      inst_cancel;
  pcbf_sel_t fcl_fdp_pcbf_sel;
  logic      fcl_fdp_valid_f;

  modport master (
    input  br_taken,
    input  exu_ifu_except,
    input  exu_ifu_ertn_e,
    input  exu_ifu_stall_req,
    input  inst_addr_ok,
    input  inst_valid_f,
    output inst_req,
    output inst_cancel,
    output fcl_fdp_pcbf_sel,
    output fcl_fdp_valid_f
  );

  modport slave (
    output br_taken,
    output exu_ifu_except,
    output exu_ifu_ertn_e,
    output exu_ifu_stall_req,
    output inst_addr_ok,
    output inst_valid_f,
    input  inst_req,
    input  inst_cancel,
    input  fcl_fdp_pcbf_sel,
    input  fcl_fdp_valid_f
  );

endinterface

// File: rtl/cpu7_ifu_fcl_dropctr.sv
// Saturating up/down counter of cancelled-but-unreturned fetch requests.
// Simultaneous inc and dec leave the count unchanged; it never wraps.
module cpu7_ifu_fcl_dropctr #(
  parameter int W   = 2,
  parameter int MAX = 3
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt,
  output logic         o_sat,
  output logic         o_nz
);

  logic [W-1:0] r_cnt;
  logic         w_sat;
  logic         w_nz;
  logic         w_dec;

  assign w_sat = (r_cnt == W'(MAX));
  assign w_nz  = (r_cnt != '0);
  assign w_dec = i_dec & w_nz;

  // Counter update: increment holds at MAX, decrement is blocked at zero.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_cnt <= '0;
    end else begin
      case ({i_inc, w_dec})
        2'b10: begin
          if (w_sat) begin
            r_cnt <= r_cnt;
          end else begin
            r_cnt <= r_cnt + W'(1);
          end
        end
        2'b01:   r_cnt <= r_cnt - W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_cnt = r_cnt;
  assign o_sat = w_sat;
  assign o_nz  = w_nz;

endmodule

// File: rtl/cpu7_ifu_fcl.sv
// IFU fetch control: sequences the instruction-memory handshake, filters stale
// responses after redirects and drives the one-hot pc_bf select for fdp.
module cpu7_ifu_fcl
  import cpu7_ifu_fcl_pkg::*;
#(
  parameter int DROP_MAX = FCL_DROP_MAX,
  parameter int DROP_W   = FCL_DROP_W
) (
  input  logic           clk,
  input  logic           rst_l,
  cpu7_ifu_fcl_if.master fcl_if
);

  fcl_state_e        r_state;
  logic              r_live;

  logic              w_run;
  logic              w_redir;
  logic              w_stale;
  logic              w_resp;
  logic              w_req;
  logic              w_accept;
  logic              w_drop_inc;
  logic [DROP_W-1:0] w_drop_cnt;
  logic              w_drop_sat;
  logic              w_drop_nz;
  pcbf_idx_e         w_sel_idx;

  assign w_run   = (r_state == ST_RUN);
  assign w_redir = w_run & (fcl_if.exu_ifu_except | fcl_if.exu_ifu_ertn_e | fcl_if.br_taken);

  // A response is stale while any cancelled request is still outstanding,
  // because memory returns in order and cancelled ones were issued first.
  assign w_stale = w_run & fcl_if.inst_valid_f & w_drop_nz;
  assign w_resp  = w_run & fcl_if.inst_valid_f & ~w_drop_nz;

  assign w_req = w_run & ~fcl_if.exu_ifu_stall_req & ~w_drop_sat
               & (~r_live | w_resp | w_redir);
  assign w_accept   = w_req & fcl_if.inst_addr_ok;
  assign w_drop_inc = w_redir & r_live & ~w_resp;

  cpu7_ifu_fcl_dropctr #(
    .W   (DROP_W),
    .MAX (DROP_MAX)
  ) u_dropctr (
    .clk   (clk),
    .rst_l (rst_l),
    .i_inc (w_drop_inc),
    .i_dec (w_stale),
    .o_cnt (w_drop_cnt),
    .o_sat (w_drop_sat),
    .o_nz  (w_drop_nz)
  );

  // Fetch sequencer: leaves INIT on the first clock after reset release.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state <= ST_INIT;
    end else begin
      case (r_state)
        ST_INIT: r_state <= ST_RUN;
        ST_RUN:  r_state <= ST_RUN;
        default: r_state <= ST_INIT;
      endcase
    end
  end

  // Outstanding live request; an accept in a redirect cycle is for the new target.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_live <= 1'b0;
    end else if (w_accept) begin
      r_live <= 1'b1;
    end else if (w_resp | w_redir) begin
      r_live <= 1'b0;
    end else begin
      r_live <= r_live;
    end
  end

  // pc_bf source priority: except > ertn > br > stall > response > hold.
  always_comb begin
    w_sel_idx = SEL_INIT;
    if (!w_run) begin
      w_sel_idx = SEL_INIT;
    end else if (fcl_if.exu_ifu_except) begin
      w_sel_idx = SEL_EXCPC;
    end else if (fcl_if.exu_ifu_ertn_e) begin
      w_sel_idx = SEL_ERTN;
    end else if (fcl_if.br_taken) begin
      w_sel_idx = SEL_BRPC;
    end else if (fcl_if.exu_ifu_stall_req) begin
      w_sel_idx = SEL_OLD;
    end else if (w_resp) begin
      w_sel_idx = SEL_PCINC;
    end else begin
      w_sel_idx = SEL_OLD;
    end
  end

  assign fcl_if.inst_req         = w_req;
  assign fcl_if.inst_cancel      = w_redir;
  assign fcl_if.fcl_fdp_pcbf_sel = pcbf_onehot(w_sel_idx);
  assign fcl_if.fcl_fdp_valid_f  = w_resp & ~w_redir & ~fcl_if.exu_ifu_stall_req;

endmodule

// File: tb/tb_cpu7_ifu_fcl.sv
// Self-checking bench for cpu7_ifu_fcl: directed scenarios with literal
// expectations, then random traffic against a request-queue reference model.
module tb_cpu7_ifu_fcl;
  import cpu7_ifu_fcl_pkg::*;

  logic clk = 1'b0;
  logic rst_l;
  always #5 clk = ~clk;

  cpu7_ifu_fcl_if bus ();

  cpu7_ifu_fcl dut (
    .clk    (clk),
    .rst_l  (rst_l),
    .fcl_if (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  bit m_run = 1'b0;

  // Model of the memory side: one entry per accepted request, oldest first.
  // want=0 means the request was cancelled by a redirect before it returned.
  bit q_want[$];
  int q_rdy[$];

  logic       s_req;
  logic       s_cancel;
  logic       s_vf;
  logic [5:0] s_sel;
  int         s_drop;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic int unw_cnt();
    int n = 0;
    foreach (q_want[i]) if (!q_want[i]) n++;
    return n;
  endfunction

  function automatic bit any_want();
    bit a = 1'b0;
    foreach (q_want[i]) if (q_want[i]) a = 1'b1;
    return a;
  endfunction

  task automatic step(input bit br, input bit ex, input bit er,
                      input bit st, input bit aok, input bit vld);
    int         unw;
    bit         anyw, redir, head_w, resp, e_req, e_vf;
    pcbf_idx_e  idx;
    logic [5:0] one;
    logic [5:0] e_sel;
    bus.br_taken          = br;
    bus.exu_ifu_except    = ex;
    bus.exu_ifu_ertn_e    = er;
    bus.exu_ifu_stall_req = st;
    bus.inst_addr_ok      = aok;
    bus.inst_valid_f      = vld;
    @(negedge clk);
    unw    = unw_cnt();
    anyw   = any_want();
    redir  = m_run && (ex || er || br);
    head_w = (q_want.size() > 0) ? q_want[0] : 1'b1;
    resp   = m_run && vld && head_w;
    e_req  = m_run && !st && (unw < FCL_DROP_MAX) && (!anyw || resp || redir);
    e_vf   = resp && !redir && !st;
    if (!m_run)    idx = SEL_INIT;
    else if (ex)   idx = SEL_EXCPC;
    else if (er)   idx = SEL_ERTN;
    else if (br)   idx = SEL_BRPC;
    else if (st)   idx = SEL_OLD;
    else if (resp) idx = SEL_PCINC;
    else           idx = SEL_OLD;
    one   = 6'd1;
    e_sel = one << idx;
    s_req    = bus.inst_req;
    s_cancel = bus.inst_cancel;
    s_vf     = bus.fcl_fdp_valid_f;
    s_sel    = bus.fcl_fdp_pcbf_sel;
    s_drop   = int'(dut.w_drop_cnt);
    chk("inst_req",    int'(s_req),    int'(e_req));
    chk("inst_cancel", int'(s_cancel), int'(redir));
    chk("pcbf_sel",    int'(s_sel),    int'(e_sel));
    chk("valid_f",     int'(s_vf),     int'(e_vf));
    chk("drop_cnt",    s_drop,         unw);
    if (vld && q_want.size() > 0) begin
      void'(q_want.pop_front());
      void'(q_rdy.pop_front());
    end
    if (redir) foreach (q_want[i]) q_want[i] = 1'b0;
    if (e_req && aok) begin
      q_want.push_back(1'b1);
      q_rdy.push_back(cyc + 1 + int'($urandom_range(0, 3)));
    end
    m_run = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    bit br, ex, er, st, aok, vld;
    int r;
    rst_l = 1'b0;
    bus.br_taken = 1'b0; bus.exu_ifu_except = 1'b0; bus.exu_ifu_ertn_e = 1'b0;
    bus.exu_ifu_stall_req = 1'b0; bus.inst_addr_ok = 1'b0; bus.inst_valid_f = 1'b0;
    #1;
    chk("rst0_req",  int'(bus.inst_req),         0);
    chk("rst0_sel",  int'(bus.fcl_fdp_pcbf_sel), 1);
    chk("rst0_vf",   int'(bus.fcl_fdp_valid_f),  0);
    repeat (2) @(posedge clk);
    #1;
    rst_l = 1'b1;

    // Streaming fetch
    step(0,0,0,0,1,0); chk("c0_sel", int'(s_sel), 1);  chk("c0_req", int'(s_req), 0);
    step(0,0,0,0,1,0); chk("c1_sel", int'(s_sel), 2);  chk("c1_req", int'(s_req), 1);
    step(0,0,0,0,1,1); chk("c2_sel", int'(s_sel), 4);  chk("c2_vf",  int'(s_vf),  1);
    step(0,0,0,0,1,1); chk("c3_sel", int'(s_sel), 4);  chk("c3_req", int'(s_req), 1);
    // Branch before data, stale response dropped
    step(1,0,0,0,0,0); chk("c4_cancel", int'(s_cancel), 1); chk("c4_sel", int'(s_sel), 8);
    step(0,0,0,0,1,1); chk("c5_vf", int'(s_vf), 0); chk("c5_drop", s_drop, 1);
    step(0,0,0,0,0,1); chk("c6_vf", int'(s_vf), 1); chk("c6_drop", s_drop, 0);
    // Three redirects fill the drop counter
    step(0,0,0,0,1,0);
    step(1,0,0,0,1,0);
    step(0,1,0,0,1,0); chk("c9_sel", int'(s_sel), 16);
    step(0,0,1,0,0,0); chk("c10_sel", int'(s_sel), 32); chk("c10_drop", s_drop, 2);
    step(0,0,0,0,1,0); chk("c11_drop", s_drop, 3); chk("c11_req", int'(s_req), 0);
    step(0,0,0,0,1,1); chk("c12_req", int'(s_req), 0);
    step(0,0,0,0,0,0); chk("c13_drop", s_drop, 2); chk("c13_req", int'(s_req), 1);
    step(0,0,0,0,0,1);
    step(0,0,0,0,0,1);
    step(0,0,0,0,1,0); chk("c16_drop", s_drop, 0);
    // Except and branch together with a live response
    step(1,1,0,0,0,1); chk("c17_sel", int'(s_sel), 16); chk("c17_vf", int'(s_vf), 0);
    step(0,0,0,0,1,0); chk("c18_drop", s_drop, 0); chk("c18_req", int'(s_req), 1);
    // Stall swallows a live response, then the same pc is refetched
    step(0,0,0,1,1,1); chk("c19_vf", int'(s_vf), 0); chk("c19_req", int'(s_req), 0);
    chk("c19_sel", int'(s_sel), 2);
    step(0,0,0,0,1,0); chk("c20_req", int'(s_req), 1); chk("c20_sel", int'(s_sel), 2);
    // Build live=1, drop=2, then async reset
    step(1,0,0,0,1,0);
    step(1,0,0,0,1,0);
    chk("pre_rst_drop", int'(dut.w_drop_cnt), 2);
    chk("pre_rst_live", int'(dut.r_live), 1);
    #2;
    rst_l = 1'b0;
    #1;
    chk("arst_req",    int'(bus.inst_req),         0);
    chk("arst_cancel", int'(bus.inst_cancel),      0);
    chk("arst_sel",    int'(bus.fcl_fdp_pcbf_sel), 1);
    chk("arst_vf",     int'(bus.fcl_fdp_valid_f),  0);
    chk("arst_drop",   int'(dut.w_drop_cnt),       0);
    chk("arst_live",   int'(dut.r_live),           0);
    q_want.delete();
    q_rdy.delete();
    m_run = 1'b0;
    bus.br_taken = 1'b0;
    bus.inst_addr_ok = 1'b0;
    @(posedge clk);
    #1;
    rst_l = 1'b1;

    // Random traffic; the memory only returns requests it has accepted
    for (int k = 0; k < 3000; k++) begin
      r  = int'($urandom_range(0, 15));
      ex = (r == 0) || (r == 4);
      er = (r == 1);
      br = (r == 2) || (r == 3) || (r == 4);
      if (unw_cnt() == FCL_DROP_MAX && any_want()) begin
        ex = 1'b0; er = 1'b0; br = 1'b0;
      end
      st  = ($urandom_range(0, 7) == 0);
      aok = ($urandom_range(0, 2) != 0);
      vld = (q_want.size() > 0) && (q_rdy[0] <= cyc) && ($urandom_range(0, 3) != 0);
      step(br, ex, er, st, aok, vld);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
